prefetch_store_buffer: RTL and testbench
========================================

Name: prefetch_store_buffer

Overview:
- Small associative store buffer that sits directly downstream of the prefetcher FSM.
- Absorbs the FSM's stack-slot writes (w_addr/w_data) and serves its store-buffer reads (strBuf_data_req/strBuf_r_addr) with the wait/ready handshake the FSM already expects.
- Reads hit on the youngest matching entry; misses return zero.
- Keeps prefetcher-private stack state off the real cache.

Parameters:
- DEPTH, 8, number of entries (power of two, 2..32)
- IDX_W, 3, log2(DEPTH)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- clear  input  1  synchronous flush of all entries; pulsed with the FSM trigger
- w_valid  input  1  write strobe for w_addr/w_data
- w_addr  input  32  store address; word granularity, bits [1:0] ignored
- w_data  input  32  store data
- rd_req  input  1  read request (strBuf_data_req), one-cycle pulse
- rd_addr  input  32  read address, sampled with rd_req
- wait_o  output  1  to FSM wait_strBuf; high while a read is in flight
- data_ready_o  output  1  to strBuf_data_ready; data_o valid this cycle
- data_o  output  32  read data (strBuf_data_i)
- hit_o  output  1  qualifies data_o: 1 = match found, 0 = miss (data_o = 0)
- count_o  output  IDX_W+1  number of valid entries
- overflow_o  output  1  one-cycle pulse when an allocation evicts the oldest entry

Behaviour:
- Reset (reset low, async): all entries invalid, head = tail = 0, count_o = 0, wait_o = 0, data_ready_o = 0, data_o = 0, hit_o = 0, overflow_o = 0, read FSM to IDLE. Reset mid-read aborts it with no response.
- Storage: circular array of {valid, addr[31:2], data}, head = oldest, tail = next free.
- Write, on an edge with w_valid = 1 and clear = 0:
  - Match on a valid entry (addr[31:2] equal): overwrite that entry's data in place (coalesce); count unchanged.
  - No match, count < DEPTH: allocate at tail, tail+1 (mod DEPTH), count+1.
  - No match, count = DEPTH: overwrite the entry at head, head+1 and tail+1 (mod DEPTH), count stays DEPTH, overflow_o = 1 next cycle.
- Clear: invalidates all entries, head = tail = count = 0. Clear wins over a same-edge write (the write is dropped).
- Read FSM, states IDLE, LOOKUP, RESP:
  - IDLE: on rd_req = 1, latch rd_addr[31:2]; wait_o = 1; go to LOOKUP.
  - LOOKUP: search all valid entries; youngest match wins (age relative to head).
    - A write on this same edge whose address matches is forwarded as youngest.
    - A clear on this same edge forces a miss.
    - Register data_o, hit_o (miss: data_o = 0, hit_o = 0); data_ready_o = 1; wait_o stays 1; go to RESP.
  - RESP: data_ready_o = 0, wait_o = 0; go to IDLE. data_o and hit_o hold until the next LOOKUP.
- Timing: request edge N gives wait_o high in cycles N+1..N+2 and data_ready_o high in cycle N+2 only. Fixed latency, one outstanding read.
- rd_req while not in IDLE is ignored; no queuing.
- A write to an address in the same cycle as its rd_req is visible to that read.
- Addresses differing only in bits [1:0] alias to the same entry.
- count_o and overflow_o are registered.

Test Plan:
- Reset then read 0x1004 → wait_o high 2 cycles, data_ready_o pulses once, hit_o = 0, data_o = 0.
- Write (0x1004, 0xAA) then read 0x1004 → hit_o = 1, data_o = 0xAA, count_o = 1. Read 0x1006 → same hit (aliasing).
- Write (0x1008, 1), then (0x1008, 2), then read 0x1008 → data_o = 2, count_o = 1 (coalesced).
- DEPTH = 8: write 9 distinct addresses 0x0, 0x4 … 0x20 → overflow_o pulses once on the 9th; count_o = 8; read 0x0 misses; read 0x20 returns its data.
- Issue rd_req for 0x14 and, in the LOOKUP cycle, write (0x14, 0x55) → data_o = 0x55, hit_o = 1. Repeat with clear instead of the write → hit_o = 0, count_o = 0.
- Drive reset low during LOOKUP → wait_o and data_ready_o drop immediately. After release: count_o = 0, and a new rd_req completes normally.

Source files
------------

// File: rtl/prefetch_store_buffer.sv
// Associative store buffer behind the prefetcher FSM: coalescing circular writes,
// fixed two-cycle reads that hit on the youngest match and return zero on a miss.
module prefetch_store_buffer #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             w_valid,
    input  logic [31:0]      w_addr,
    input  logic [31:0]      w_data,
    input  logic             rd_req,
    input  logic [31:0]      rd_addr,
    output logic             wait_o,
    output logic             data_ready_o,
    output logic [31:0]      data_o,
    output logic             hit_o,
    output logic [IDX_W:0]   count_o,
    output logic             overflow_o
);

    // IDLE: no read | LOOKUP: search entries this cycle | RESP: result presented
    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP} state_t;

    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

    state_t             r_state, w_state_nxt;
    logic [DEPTH-1:0]   r_valid;
    logic [29:0]        r_addr [DEPTH];
    logic [31:0]        r_data [DEPTH];
    logic [IDX_W-1:0]   r_head, r_tail;
    logic [IDX_W:0]     r_count;
    logic               r_overflow;
    logic [29:0]        r_rd_addr;
    logic [31:0]        r_data_o;
    logic               r_hit_o;

    logic               w_wr_hit;
    logic [IDX_W-1:0]   w_wr_idx;
    logic               w_rd_hit;
    logic [31:0]        w_rd_data;
    logic [IDX_W-1:0]   w_age_idx;
    logic               w_unused_bits;

    assign w_unused_bits = ^{w_addr[1:0], rd_addr[1:0]};

    always_comb begin
        w_wr_hit = 1'b0;
        w_wr_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && r_addr[i] == w_addr[31:2]) begin
                w_wr_hit = 1'b1;
                w_wr_idx = IDX_W'(i);
            end
        end
    end

    // Walk oldest to youngest so the last match wins; a same-edge write is younger still.
    always_comb begin
        w_rd_hit  = 1'b0;
        w_rd_data = '0;
        w_age_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_age_idx = r_head + IDX_W'(k);
            if (r_valid[w_age_idx] && r_addr[w_age_idx] == r_rd_addr) begin
                w_rd_hit  = 1'b1;
                w_rd_data = r_data[w_age_idx];
            end
        end
        if (w_valid && w_addr[31:2] == r_rd_addr) begin
            w_rd_hit  = 1'b1;
            w_rd_data = w_data;
        end
        if (clear) begin
            w_rd_hit  = 1'b0;
            w_rd_data = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_overflow <= 1'b0;
            if (clear) begin
                r_valid <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else if (w_valid) begin
                if (w_wr_hit) begin
                    r_data[w_wr_idx] <= w_data;
                end else if (r_count < FULL) begin
                    r_valid[r_tail] <= 1'b1;
                    r_addr[r_tail]  <= w_addr[31:2];
                    r_data[r_tail]  <= w_data;
                    r_tail          <= r_tail + 1'b1;
                    r_count         <= r_count + 1'b1;
                end else begin
                    r_addr[r_head] <= w_addr[31:2];
                    r_data[r_head] <= w_data;
                    r_head         <= r_head + 1'b1;
                    r_tail         <= r_tail + 1'b1;
                    r_overflow     <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_rd_addr <= '0;
            r_data_o  <= '0;
            r_hit_o   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && rd_req) begin
                r_rd_addr <= rd_addr[31:2];
            end
            if (r_state == S_LOOKUP) begin
                r_data_o <= w_rd_data;
                r_hit_o  <= w_rd_hit;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (rd_req) w_state_nxt = S_LOOKUP;
            S_LOOKUP: w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        wait_o       = (r_state == S_LOOKUP) || (r_state == S_RESP);
        data_ready_o = (r_state == S_RESP);
    end

    assign data_o     = r_data_o;
    assign hit_o      = r_hit_o;
    assign count_o    = r_count;
    assign overflow_o = r_overflow;

endmodule

// File: tb/tb_prefetch_store_buffer.sv
// Directed bench for prefetch_store_buffer: hand-computed expectations checked with
// immediate assertions after each step.
module tb_prefetch_store_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        w_valid = 1'b0;
    logic [31:0] w_addr = '0;
    logic [31:0] w_data = '0;
    logic        rd_req = 1'b0;
    logic [31:0] rd_addr = '0;
    logic        wait_o, data_ready_o, hit_o, overflow_o;
    logic [31:0] data_o;
    logic [3:0]  count_o;

    int n_cmp = 0;
    int n_err = 0;

    prefetch_store_buffer #(.DEPTH(8), .IDX_W(3)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .wait_o(wait_o), .data_ready_o(data_ready_o), .data_o(data_o),
        .hit_o(hit_o), .count_o(count_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        w_valid = 1'b1; w_addr = a; w_data = d;
        tick();
        w_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [31:0] a,
                           input logic exp_hit, input logic [31:0] exp_data);
        rd_req = 1'b1; rd_addr = a;
        tick();
        rd_req = 1'b0;
        check({tag, "_wait1"}, {31'b0, wait_o}, 32'd1);
        check({tag, "_rdy1"},  {31'b0, data_ready_o}, 32'd0);
        tick();
        check({tag, "_wait2"}, {31'b0, wait_o}, 32'd1);
        check({tag, "_rdy2"},  {31'b0, data_ready_o}, 32'd1);
        check({tag, "_hit"},   {31'b0, hit_o}, {31'b0, exp_hit});
        check({tag, "_data"},  data_o, exp_data);
        tick();
        check({tag, "_wait3"}, {31'b0, wait_o}, 32'd0);
        check({tag, "_rdy3"},  {31'b0, data_ready_o}, 32'd0);
    endtask

    initial begin
        // reset state
        #3;
        check("rst_count", {28'b0, count_o}, 32'd0);
        check("rst_wait",  {31'b0, wait_o}, 32'd0);
        check("rst_rdy",   {31'b0, data_ready_o}, 32'd0);
        check("rst_data",  data_o, 32'd0);
        check("rst_hit",   {31'b0, hit_o}, 32'd0);
        check("rst_ovf",   {31'b0, overflow_o}, 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();

        do_read("miss_empty", 32'h1004, 1'b0, 32'h0);

        do_write(32'h1004, 32'hAA);
        check("cnt_after_w1", {28'b0, count_o}, 32'd1);
        do_read("hit_1004", 32'h1004, 1'b1, 32'hAA);
        do_read("alias_1006", 32'h1006, 1'b1, 32'hAA);

        do_clear();
        check("cnt_after_clr", {28'b0, count_o}, 32'd0);
        do_write(32'h1008, 32'h1);
        do_write(32'h1008, 32'h2);
        check("cnt_coalesce", {28'b0, count_o}, 32'd1);
        do_read("coalesce", 32'h1008, 1'b1, 32'h2);

        // fill past capacity: ninth distinct address evicts 0x0
        do_clear();
        for (int i = 0; i < 9; i++) begin
            do_write(32'(i * 4), 32'h100 + 32'(i));
            check($sformatf("fill_ovf%0d", i), {31'b0, overflow_o}, (i == 8) ? 32'd1 : 32'd0);
            check($sformatf("fill_cnt%0d", i), {28'b0, count_o}, (i < 8) ? 32'(i + 1) : 32'd8);
        end
        do_read("evicted_0", 32'h0, 1'b0, 32'h0);
        check("ovf_dropped", {31'b0, overflow_o}, 32'd0);
        do_read("newest_20", 32'h20, 1'b1, 32'h108);
        do_read("kept_4", 32'h4, 1'b1, 32'h101);
        check("cnt_full", {28'b0, count_o}, 32'd8);

        // same-edge write in LOOKUP is forwarded over the stored 0x105
        rd_req = 1'b1; rd_addr = 32'h14;
        tick();
        rd_req = 1'b0;
        w_valid = 1'b1; w_addr = 32'h14; w_data = 32'h55;
        tick();
        w_valid = 1'b0;
        check("fwd_rdy",  {31'b0, data_ready_o}, 32'd1);
        check("fwd_hit",  {31'b0, hit_o}, 32'd1);
        check("fwd_data", data_o, 32'h55);
        check("fwd_cnt",  {28'b0, count_o}, 32'd8);
        tick();

        // same-edge clear in LOOKUP forces a miss
        rd_req = 1'b1; rd_addr = 32'h14;
        tick();
        rd_req = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_rdy",  {31'b0, data_ready_o}, 32'd1);
        check("clr_hit",  {31'b0, hit_o}, 32'd0);
        check("clr_data", data_o, 32'h0);
        check("clr_cnt",  {28'b0, count_o}, 32'd0);
        tick();

        // reset asserted mid-LOOKUP aborts the read
        do_write(32'h30, 32'h77);
        check("pre_rst_cnt", {28'b0, count_o}, 32'd1);
        rd_req = 1'b1; rd_addr = 32'h30;
        tick();
        rd_req = 1'b0;
        check("lookup_wait", {31'b0, wait_o}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_wait", {31'b0, wait_o}, 32'd0);
        check("abort_rdy",  {31'b0, data_ready_o}, 32'd0);
        tick();
        check("abort_rdy_hold", {31'b0, data_ready_o}, 32'd0);
        reset = 1'b1;
        tick();
        check("post_rst_cnt", {28'b0, count_o}, 32'd0);
        do_read("post_rst_miss", 32'h30, 1'b0, 32'h0);
        do_write(32'h40, 32'h99);
        do_read("post_rst_hit", 32'h40, 1'b1, 32'h99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
